perf_checkpoint_monitor: RTL and testbench

- Synthesizable cycle-count monitor for the management SoC performance test.
- Sits directly downstream of the user-project GPIO pads and consumes the 16-bit checkpoint word that firmware drives on mprj_io[31:16].
- Detects the start and end marker codes, measures elapsed clock cycles in kilocycle units, and flags a watchdog timeout.
- Results go to a wishbone-readable status register and logic-analyzer probes for on-silicon performance runs.

---
 rtl/perf_checkpoint_monitor.sv | 171 +++++++++++++++++
 tb/tb_perf_checkpoint_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_checkpoint_monitor.sv
// Cycle-count monitor for firmware checkpoint words on the user GPIO pads.
// Measures START->END time in kilocycles and flags a watchdog expiry.
module perf_checkpoint_monitor #(
  parameter logic [15:0] START_CODE    = 16'hA000,
  parameter logic [15:0] END_CODE      = 16'hAB00,
  parameter int          PRESCALE      = 1000,
  parameter int          TIMEOUT_KC    = 150,
  parameter int          KC_WIDTH      = 32,
  parameter int          STABLE_CYCLES = 2
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic [15:0]         checkbits,
  input  logic                enable,
  input  logic                clear,
  output logic                running,
  output logic                done,
  output logic                timeout,
  output logic                done_pulse,
  output logic [KC_WIDTH-1:0] kcycles,
  output logic [9:0]          subcycles
);

  localparam int                  RUN_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0]    RUN_MAX  = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0]    RUN_ONE  = RUN_W'(1);
  localparam logic [9:0]          SUB_MAX  = 10'(PRESCALE - 1);
  localparam logic [KC_WIDTH-1:0] WD_LIMIT = KC_WIDTH'(TIMEOUT_KC);
  localparam logic [KC_WIDTH-1:0] KC_ONE   = KC_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  function automatic logic [KC_WIDTH-1:0] sat_inc(input logic [KC_WIDTH-1:0] v);
    return (v == {KC_WIDTH{1'b1}}) ? v : v + KC_ONE;
  endfunction

  logic [15:0]      ckpt_p0, ckpt_p1, cand_p2;
  logic [RUN_W-1:0] run_cnt_p2;
  logic [RUN_W-1:0] run_nxt;
  logic             same, accept, start_acc, end_acc;

  state_t              state;
  logic [9:0]          wd_sub;
  logic [KC_WIDTH-1:0] wd_kc;
  logic                wd_expire, counting;

  // Stage p0/p1: two-flop synchronizer; keeps tracking the pads even when disabled.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ckpt_p0 <= '0;
      ckpt_p1 <= '0;
    end else begin
      ckpt_p0 <= checkbits;
      ckpt_p1 <= ckpt_p0;
    end
  end

  // Stage p2: stability filter; a run of equal samples fires exactly once.
  always_comb begin
    same = (ckpt_p1 == cand_p2);
    if (!same)
      run_nxt = RUN_ONE;
    else if (run_cnt_p2 == RUN_MAX)
      run_nxt = RUN_MAX;
    else
      run_nxt = run_cnt_p2 + RUN_ONE;
    accept    = (run_nxt == RUN_MAX) && !(same && (run_cnt_p2 == RUN_MAX));
    start_acc = accept && (ckpt_p1 == START_CODE);
    end_acc   = accept && (ckpt_p1 == END_CODE);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cand_p2    <= '0;
      run_cnt_p2 <= '0;
    end else begin
      cand_p2    <= ckpt_p1;
      run_cnt_p2 <= run_nxt;
    end
  end

  // Watchdog expires on the edge where its kilocycle count would reach the limit.
  always_comb begin
    counting  = (state == ST_IDLE) || (state == ST_RUN);
    wd_expire = (wd_kc >= WD_LIMIT) ||
                ((wd_sub == SUB_MAX) && (wd_kc == WD_LIMIT - KC_ONE));
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      done_pulse <= 1'b0;
      kcycles    <= '0;
      subcycles  <= '0;
      wd_sub     <= '0;
      wd_kc      <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (clear) begin
        state     <= ST_IDLE;
        running   <= 1'b0;
        done      <= 1'b0;
        timeout   <= 1'b0;
        kcycles   <= '0;
        subcycles <= '0;
        wd_sub    <= '0;
        wd_kc     <= '0;
      end else if (enable) begin
        if (counting) begin
          if (subcycles == SUB_MAX) begin
            subcycles <= '0;
            kcycles   <= sat_inc(kcycles);
          end else begin
            subcycles <= subcycles + 10'd1;
          end
          if (wd_sub == SUB_MAX) begin
            wd_sub <= '0;
            wd_kc  <= sat_inc(wd_kc);
          end else begin
            wd_sub <= wd_sub + 10'd1;
          end
        end
        // Later assignments below override the free-running count above.
        case (state)
          ST_IDLE: begin
            if (wd_expire) begin
              state     <= ST_TOUT;
              timeout   <= 1'b1;
              kcycles   <= kcycles;
              subcycles <= subcycles;
            end else if (start_acc) begin
              state     <= ST_RUN;
              running   <= 1'b1;
              kcycles   <= '0;
              subcycles <= '0;
            end
          end
          ST_RUN: begin
            if (end_acc) begin
              state      <= ST_DONE;
              running    <= 1'b0;
              done       <= 1'b1;
              done_pulse <= 1'b1;
              kcycles    <= kcycles;
              subcycles  <= subcycles;
            end else if (wd_expire) begin
              state     <= ST_TOUT;
              running   <= 1'b0;
              timeout   <= 1'b1;
              kcycles   <= kcycles;
              subcycles <= subcycles;
            end else if (start_acc) begin
              kcycles   <= '0;
              subcycles <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perf_checkpoint_monitor.sv
// Scoreboard bench for perf_checkpoint_monitor: expectations are queued as
// stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_perf_checkpoint_monitor;

  localparam int          PRESCALE   = 1000;
  localparam int          TIMEOUT_KC = 20;
  localparam int          STABLE     = 2;
  localparam int          LAT        = 2 + STABLE;
  localparam logic [15:0] START      = 16'hA000;
  localparam logic [15:0] ENDC       = 16'hAB00;

  logic        clock = 1'b0;
  logic        resetb, enable, clear;
  logic [15:0] checkbits;
  logic        running, done, timeout, done_pulse;
  logic [31:0] kcycles;
  logic [9:0]  subcycles;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t exp_q[$];

  perf_checkpoint_monitor #(
    .START_CODE(START), .END_CODE(ENDC), .PRESCALE(PRESCALE),
    .TIMEOUT_KC(TIMEOUT_KC), .KC_WIDTH(32), .STABLE_CYCLES(STABLE)
  ) dut (
    .clock(clock), .resetb(resetb), .checkbits(checkbits), .enable(enable),
    .clear(clear), .running(running), .done(done), .timeout(timeout),
    .done_pulse(done_pulse), .kcycles(kcycles), .subcycles(subcycles)
  );

  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("FAIL sim_time_limit: observed still running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [63:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_empty: observed %0d expected none", obs);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic expect_out(input string tag, input bit r, input bit d, input bit t,
                            input bit p, input int elapsed);
    push_exp({tag, ".running"}, 64'(r));
    push_exp({tag, ".done"}, 64'(d));
    push_exp({tag, ".timeout"}, 64'(t));
    push_exp({tag, ".done_pulse"}, 64'(p));
    push_exp({tag, ".kcycles"}, 64'(elapsed / PRESCALE));
    push_exp({tag, ".subcycles"}, 64'(elapsed % PRESCALE));
  endtask

  task automatic compare_out();
    pop_cmp(64'(running));
    pop_cmp(64'(done));
    pop_cmp(64'(timeout));
    pop_cmp(64'(done_pulse));
    pop_cmp(64'(kcycles));
    pop_cmp(64'(subcycles));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    int elapsed;
    resetb = 1'b0; enable = 1'b0; clear = 1'b0; checkbits = '0;
    step(3);
    resetb = 1'b1;
    expect_out("idle", 0, 0, 0, 0, 0);
    step(10);
    compare_out();

    // Basic measurement: both markers see the same filter latency, and the
    // END edge freezes the pre-edge count, so elapsed = drive spacing - 1.
    enable = 1'b1;
    pulse_clear();
    checkbits = START;
    expect_out("start", 1, 0, 0, 0, 0);
    step(LAT);
    compare_out();
    step(12345 - LAT);
    checkbits = ENDC;
    elapsed = 12345 - 1;
    expect_out("basic_done", 0, 1, 0, 1, elapsed);
    step(LAT);
    compare_out();
    expect_out("basic_pulse_end", 0, 1, 0, 0, elapsed);
    step(1);
    compare_out();
    checkbits = START;
    expect_out("done_sticky", 0, 1, 0, 0, elapsed);
    step(3 * LAT);
    compare_out();

    // Glitch rejection then a held END.
    checkbits = '0;
    pulse_clear();
    checkbits = START;
    step(LAT + 10);
    checkbits = ENDC;
    step(1);
    checkbits = '0;
    expect_out("glitch_reject", 1, 0, 0, 0, 19);
    step(2 * LAT);
    compare_out();
    checkbits = ENDC;
    expect_out("glitch_held", 0, 1, 0, 1, 22);
    step(3);
    checkbits = '0;
    step(1);
    compare_out();

    // Restart with an unrelated code in between.
    pulse_clear();
    checkbits = START;
    step(LAT + 5000);
    checkbits = 16'h1234;
    expect_out("other_code", 1, 0, 0, 0, 5010);
    step(10);
    compare_out();
    checkbits = START;
    step(3500);
    checkbits = ENDC;
    expect_out("restart", 0, 1, 0, 1, 3499);
    step(LAT);
    compare_out();

    // Enable low holds counters.
    checkbits = '0;
    pulse_clear();
    checkbits = START;
    step(LAT + 1500);
    enable = 1'b0;
    expect_out("enable_hold", 1, 0, 0, 0, 1500);
    step(500);
    compare_out();
    enable = 1'b1;
    expect_out("enable_resume", 1, 0, 0, 0, 2500);
    step(1000);
    compare_out();

    // Watchdog expiry TIMEOUT_KC*PRESCALE cycles after clear.
    checkbits = '0;
    pulse_clear();
    checkbits = START;
    expect_out("pre_timeout", 1, 0, 0, 0, TIMEOUT_KC * PRESCALE - 1 - LAT);
    step(TIMEOUT_KC * PRESCALE - 1);
    compare_out();
    expect_out("timeout", 0, 0, 1, 0, TIMEOUT_KC * PRESCALE - 1 - LAT);
    step(1);
    compare_out();
    checkbits = ENDC;
    expect_out("timeout_sticky", 0, 0, 1, 0, TIMEOUT_KC * PRESCALE - 1 - LAT);
    step(3 * LAT);
    compare_out();
    clear = 1'b1;
    expect_out("clear", 0, 0, 0, 0, 0);
    step(1);
    compare_out();
    clear = 1'b0;

    // END accepted on the same edge the watchdog expires: DONE wins.
    checkbits = '0;
    pulse_clear();
    checkbits = START;
    step(TIMEOUT_KC * PRESCALE - LAT);
    checkbits = ENDC;
    expect_out("end_vs_timeout", 0, 1, 0, 1, TIMEOUT_KC * PRESCALE - 1 - LAT);
    step(LAT);
    compare_out();
    expect_out("end_vs_timeout_later", 0, 1, 0, 0, TIMEOUT_KC * PRESCALE - 1 - LAT);
    step(5);
    compare_out();

    // Asynchronous reset in the middle of a run.
    checkbits = '0;
    pulse_clear();
    checkbits = START;
    expect_out("pre_reset", 1, 0, 0, 0, 100);
    step(LAT + 100);
    compare_out();
    #2;
    resetb = 1'b0;
    expect_out("async_reset", 0, 0, 0, 0, 0);
    #1;
    compare_out();
    step(2);
    resetb = 1'b1;
    step(2);

    check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
